alu_reg_sequencer: RTL

Command-driven controller that sequences the shared 4-bit ALU and the 4-bit control register (cl/ld/inc/dec/sr/sl with ir/il fill) as an accumulator datapath. It accepts one command at a time over a valid/ready handshake. It expands each command into the correct per-cycle register control pulses and ALU operand/opcode drive, then returns the resulting register value on a single-cycle response strobe. The block sits between a host/test sequencer and the existing alu and register instances; it does not contain them.

---
 rtl/seq_pkg.sv | 29 ++
 rtl/seq_repeat_cnt.sv | 26 ++
 rtl/alu_reg_sequencer.sv | 99 +++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// seq_pkg: command codes, FSM states and default widths shared by the ALU/register sequencer.
package seq_pkg;

    localparam int DEF_DATA_W = 4;
    localparam int DEF_CNT_W  = 2;

    typedef enum logic [2:0] {
        CMD_CLR  = 3'd0,
        CMD_LOAD = 3'd1,
        CMD_ALU  = 3'd2,
        CMD_SHL  = 3'd3,
        CMD_SHR  = 3'd4,
        CMD_INC  = 3'd5,
        CMD_DEC  = 3'd6,
        CMD_READ = 3'd7
    } cmd_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Commands that pulse their register control cnt+1 times instead of once.
    function automatic logic is_repeat(input cmd_e op);
        return op inside {CMD_SHL, CMD_SHR, CMD_INC, CMD_DEC};
    endfunction

endpackage

// File: rtl/seq_repeat_cnt.sv
// seq_repeat_cnt: loadable down-counter whose zero flag ends the EXEC phase.
module seq_repeat_cnt
    import seq_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] value,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    // Load the remaining repeat count at accept, then count down once per extra EXEC cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) count <= '0;
        else if (load) count <= value;
        else if (dec) count <= count - CNT_W'(1);
    end

    assign zero = count == '0;

endmodule

// File: rtl/alu_reg_sequencer.sv
// alu_reg_sequencer: expands host commands into per-cycle ALU/register control for an accumulator datapath.
module alu_reg_sequencer
    import seq_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic [2:0]        cmd_oc,
    input  logic [CNT_W-1:0]  cmd_cnt,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_oc,
    input  logic [DATA_W-1:0] alu_f,
    output logic              reg_cl,
    output logic              reg_ld,
    output logic              reg_inc,
    output logic              reg_dec,
    output logic              reg_sr,
    output logic              reg_sl,
    output logic              reg_ir,
    output logic              reg_il,
    output logic [DATA_W-1:0] reg_in,
    input  logic [DATA_W-1:0] reg_out,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy
);

    state_e            state;
    cmd_e              op_q;
    cmd_e              op_in;
    logic [DATA_W-1:0] data_q;
    logic [2:0]        oc_q;
    logic              accept;
    logic              in_exec;
    logic              cnt_zero;

    assign op_in     = cmd_e'(cmd_op);
    // Held low during reset itself, not only after the state has been cleared.
    assign cmd_ready = state == S_IDLE && !rst;
    assign accept    = cmd_valid && cmd_ready;
    assign in_exec   = state == S_EXEC;

    // Single-pulse commands load 0 so EXEC lasts exactly one cycle.
    seq_repeat_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .load  (accept),
        .dec   (in_exec && !cnt_zero),
        .value (is_repeat(op_in) ? cmd_cnt : '0),
        .zero  (cnt_zero)
    );

    // Command latch and IDLE -> EXEC -> DONE sequencing; READ skips straight to DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            op_q   <= CMD_CLR;
            data_q <= '0;
            oc_q   <= '0;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    op_q   <= op_in;
                    data_q <= cmd_data;
                    oc_q   <= cmd_oc;
                    state  <= op_in == CMD_READ ? S_DONE : S_EXEC;
                end
                S_EXEC: if (cnt_zero) state <= S_DONE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign alu_a  = reg_out;
    assign alu_b  = data_q;
    assign alu_oc = oc_q;

    assign reg_cl  = in_exec && op_q == CMD_CLR;
    assign reg_ld  = in_exec && (op_q == CMD_LOAD || op_q == CMD_ALU);
    assign reg_inc = in_exec && op_q == CMD_INC;
    assign reg_dec = in_exec && op_q == CMD_DEC;
    assign reg_sr  = in_exec && op_q == CMD_SHR;
    assign reg_sl  = in_exec && op_q == CMD_SHL;
    assign reg_ir  = reg_sr && data_q[0];
    assign reg_il  = reg_sl && data_q[0];
    assign reg_in  = !in_exec ? '0 : op_q == CMD_LOAD ? data_q : op_q == CMD_ALU ? alu_f : '0;

    assign rsp_valid = state == S_DONE;
    assign rsp_data  = rsp_valid ? reg_out : '0;
    assign busy      = state != S_IDLE;

endmodule
